shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Upstream command stage for the team's 8-bit combinational shifter (inputs A, ir, amt[2:0]; output Y).
- Accepts shift commands with a 4-bit total amount (0-15) over a valid/ready handshake.
- Splits each amount into passes of at most 7 and drives them through the shifter one pass per cycle, feeding each Y back as the next A.
- Presents the final result on a valid/ready output.

Parameters:
- DATA_W, 8, data width; fixed at 8 to match the shifter.
- AMT_W, 4, width of the requested total shift amount.
- STEP_MAX, 7, largest amount per shifter pass; equals the 3-bit amt range.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  command valid.
- in_ready  output  1  block can accept a command.
- in_data  input  8  operand.
- in_dir  input  1  0 = shift right, 1 = shift left (same encoding as the shifter's ir).
- in_amt  input  4  total shift amount, 0-15.
- sh_a  output  8  to shifter A.
- sh_ir  output  1  to shifter ir.
- sh_amt  output  3  to shifter amt.
- sh_y  input  8  from shifter Y, combinational return in the same cycle.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  8  result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0, async):
  - State goes to IDLE; work, rem and dir registers clear to 0.
  - Outputs: in_ready=1 once reset is released, out_valid=0, out_data=0, busy=0, sh_a=0, sh_ir=0, sh_amt=0.
  - Reset mid-operation aborts the command with no output.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: work<=in_data, dir<=in_dir, rem<=in_amt.
  - Next state is SHIFT if in_amt!=0, else DONE.
  - in_valid=0 leaves all state unchanged.
- SHIFT:
  - Drives sh_a=work, sh_ir=dir, sh_amt=min(rem,7).
  - Each edge: work<=sh_y, rem<=rem-min(rem,7).
  - When the new rem is 0, next state is DONE.
  - Pass sequence for amt 15 is 7,7,1; for amt 8 it is 7,1.
- DONE:
  - out_valid=1, out_data=work.
  - Both hold stable until out_ready=1; on that edge, go to IDLE.
- in_ready=0 in SHIFT and DONE. Commands offered then are not accepted and must be re-presented; there is no same-cycle accept on leaving DONE.
- Latency from the accept edge to the first cycle of out_valid: 1 + ceil(amt/7) cycles.
  - amt 0: 1 cycle.
  - amt 1-7: 2 cycles.
  - amt 8-14: 3 cycles.
  - amt 15: 4 cycles.
- Outside SHIFT: sh_a=work, sh_ir=dir, sh_amt=0. The shifter output is ignored in those states.
- Shifts are logical with zero fill; amt>=8 always yields 0x00. This relies on the shifter being logical; the block does no correction.
- No arithmetic overflow: rem only decreases and saturates at 0.
- out_data is registered; there are no combinational paths from in_* to out_*.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} seq_state_t.
  - localparams DATA_W, AMT_W, STEP_MAX.
- No sub-module inside the block. The shifter is instantiated beside it at the next level up, wired via the sh_* ports.
- The testbench instantiates the real shifter, or a logical-shift model, as the sh_y source.

Test Plan:
- in_data=0x81, dir=0, amt=3 -> one SHIFT pass with sh_amt=3; out_valid 2 cycles after accept; out_data=0x10.
- in_data=0xFF, dir=1, amt=15 -> sh_amt sequence 7,7,1; out_valid 4 cycles after accept; out_data=0x00; busy high throughout.
- in_data=0xA5, amt=0 -> no SHIFT cycle; out_valid 1 cycle after accept; out_data=0xA5.
- in_data=0x01, dir=1, amt=9, out_ready held 0 for 5 cycles -> out_data=0x00 and out_valid held steady the whole time; second in_valid during this window is not accepted (in_ready=0); IDLE one cycle after out_ready=1.
- in_data=0xF0, dir=0, amt=8 -> passes 7,1; out_data=0x00. Same with amt=4 -> out_data=0x0F.
- Reset pulse mid-SHIFT on the amt=15 command -> immediate IDLE; out_valid never rises; next command (0x3C, dir=1, amt=2) -> 0xF0.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the shift command sequencer.
// Pass splitting keeps every shifter pass inside the 3-bit amount range.
package shift_pkg;

    localparam int DATA_W   = 8;
    localparam int AMT_W    = 4;
    localparam int STEP_MAX = 7;
    localparam int STEP_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } seq_state_t;

    // Amount for the next shifter pass: the remaining total, capped at STEP_MAX.
    function automatic logic [STEP_W-1:0] pass_amt(input logic [AMT_W-1:0] rem);
        if (rem > AMT_W'(STEP_MAX)) begin
            return STEP_W'(STEP_MAX);
        end
        return rem[STEP_W-1:0];
    endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Accepts shift commands of up to 15 positions and runs them through an external
// 8-bit shifter in passes of at most 7, feeding each result back as the next operand.
module shift_sequencer
    import shift_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic [AMT_W-1:0]  in_amt,
    output logic [DATA_W-1:0] sh_a,
    output logic              sh_ir,
    output logic [STEP_W-1:0] sh_amt,
    input  logic [DATA_W-1:0] sh_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both
    // high; valid and its payload hold steady until that edge; ready never depends
    // combinationally on valid.
    seq_state_t        state_q, state_d;
    logic [DATA_W-1:0] work_q, work_d;
    logic [AMT_W-1:0]  rem_q, rem_d;
    logic              dir_q, dir_d;
    logic [STEP_W-1:0] step;

    assign step = pass_amt(rem_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            rem_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rem_d   = rem_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d  = in_data;
                    dir_d   = in_dir;
                    rem_d   = in_amt;
                    state_d = (in_amt != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                work_d = sh_y;
                rem_d  = rem_q - AMT_W'(step);
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from flops, so nothing on in_* reaches out_* in the same cycle.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        out_data  = (state_q == DONE) ? work_q : '0;
        sh_a      = work_q;
        sh_ir     = dir_q;
        sh_amt    = (state_q == SHIFT) ? step : '0;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: logical shifter model on sh_*, a pass-queue reference
// model checked every cycle, directed literal cases and randomized commands.
module tb_shift_sequencer;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic [3:0] in_amt;
    logic [7:0] sh_a;
    logic       sh_ir;
    logic [2:0] sh_amt;
    logic [7:0] sh_y;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;

    int vectors;
    int miscompares;

    shift_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .sh_a      (sh_a),
        .sh_ir     (sh_ir),
        .sh_amt    (sh_amt),
        .sh_y      (sh_y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // Logical zero-fill shifter standing in for the real one.
    assign sh_y = sh_ir ? (sh_a << sh_amt) : (sh_a >> sh_amt);

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish", $time);
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic dir, input logic [3:0] amt);
        logic [7:0] r;
        if (amt >= 4'd8) return 8'h00;
        r = dir ? (d << amt) : (d >> amt);
        return r;
    endfunction

    // ---------------- reference model ----------------
    // m_phase: 0 waiting for a command, 1 passes outstanding, 2 result offered.
    int         m_phase;
    int         pass_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] m_work;
    logic       m_dir;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_work  = 8'h00;
            m_dir   = 1'b0;
            pass_q.delete();
            exp_q.delete();
        end else begin
            if (m_phase == 0) begin
                if (in_valid) begin
                    int r;
                    m_work = in_data;
                    m_dir  = in_dir;
                    exp_q.push_back(ref_shift(in_data, in_dir, in_amt));
                    r = int'(in_amt);
                    while (r > 0) begin
                        pass_q.push_back((r > 7) ? 7 : r);
                        r = r - ((r > 7) ? 7 : r);
                    end
                    m_phase = (pass_q.size() == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                int p;
                p = pass_q.pop_front();
                m_work = m_dir ? (m_work << p) : (m_work >> p);
                if (pass_q.size() == 0) m_phase = 2;
            end else begin
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    m_phase = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("in_ready", in_ready, (m_phase == 0));
            check("busy", busy, (m_phase != 0));
            check("out_valid", out_valid, (m_phase == 2));
            check("sh_a", sh_a, m_work);
            check("sh_ir", sh_ir, m_dir);
            check("sh_amt", sh_amt, (m_phase == 1) ? pass_q[0] : 0);
            if (m_phase == 2) begin
                check("out_data", out_data, exp_q[0]);
                check("model_result", m_work, exp_q[0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic dir, input logic [3:0] amt,
                        input int hold, input logic [7:0] exp_data, input int exp_lat,
                        input bit poke_busy);
        int n;
        int lat;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check("accept_timeout", 0, 1);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_amt   = amt;
        tick();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", lat, exp_lat);
        check("result", out_data, exp_data);
        for (int i = 0; i < hold; i++) begin
            if (poke_busy) begin
                in_valid = 1'b1;
                in_data  = 8'h5A;
                in_dir   = 1'b1;
                in_amt   = 4'd1;
            end
            tick();
            check("hold_in_ready", in_ready, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_out_data", out_data, exp_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("back_to_idle", in_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        in_dir      = 1'b0;
        in_amt      = 4'd0;
        out_ready   = 1'b0;
        repeat (3) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_sh_a", sh_a, 0);
        check("rst_sh_ir", sh_ir, 0);
        check("rst_sh_amt", sh_amt, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", in_ready, 1);

        send(8'h81, 1'b0, 4'd3, 0, 8'h10, 2, 1'b0);
        send(8'hFF, 1'b1, 4'd15, 0, 8'h00, 4, 1'b0);
        send(8'hA5, 1'b0, 4'd0, 0, 8'hA5, 1, 1'b0);
        send(8'h01, 1'b1, 4'd9, 5, 8'h00, 3, 1'b1);
        send(8'hF0, 1'b0, 4'd8, 0, 8'h00, 3, 1'b0);
        send(8'hF0, 1'b0, 4'd4, 0, 8'h0F, 2, 1'b0);

        // Reset in the middle of a 15-position command.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        in_dir   = 1'b1;
        in_amt   = 4'd15;
        tick();
        in_valid = 1'b0;
        tick();
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_busy", busy, 0);
        check("mid_reset_out_valid", out_valid, 0);
        #1;
        rst_n = 1'b1;
        check("mid_reset_in_ready", in_ready, 1);
        repeat (4) begin
            tick();
            check("post_reset_no_output", out_valid, 0);
        end
        send(8'h3C, 1'b1, 4'd2, 0, 8'hF0, 2, 1'b0);

        for (int k = 0; k < 150; k++) begin
            logic [7:0] d;
            logic       dir;
            logic [3:0] amt;
            int         hold;
            d    = 8'($urandom_range(0, 255));
            dir  = 1'($urandom_range(0, 1));
            amt  = 4'($urandom_range(0, 15));
            hold = $urandom_range(0, 3);
            send(d, dir, amt, hold, ref_shift(d, dir, amt), 1 + (int'(amt) + 6) / 7,
                 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
